// File: rtl/ceyloniac_register_file_if.sv
// Bundle of the register file's read, write and status signals.
// The master modport belongs to the core's datapath and the slave modport belongs to the register file.
interface ceyloniac_register_file_if #(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic [REG_ADDR_WIDTH-1:0] read_reg1;
  logic [REG_ADDR_WIDTH-1:0] read_reg2;
  logic [RAM_DATA_WIDTH-1:0] read_data1;
  logic [RAM_DATA_WIDTH-1:0] read_data2;
  logic                      reg_write;
  logic [REG_ADDR_WIDTH-1:0] write_reg;
  logic [RAM_DATA_WIDTH-1:0] write_data;
  logic                      rf_ready;
  logic                      write_dropped;

  modport master (
    output read_reg1, read_reg2, reg_write, write_reg, write_data,
    input  read_data1, read_data2, rf_ready, write_dropped
  );

  modport slave (
    input  read_reg1, read_reg2, reg_write, write_reg, write_data,
    output read_data1, read_data2, rf_ready, write_dropped
  );
endinterface

// File: rtl/ceyloniac_register_file.sv
// General-purpose register file: two combinational read ports and one write port with write-first bypass.
// After reset, a sweep clears the array one entry per cycle so that the storage needs no per-entry reset.
module ceyloniac_register_file #(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  ceyloniac_register_file_if.slave   bus
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX = REG_ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                      rf_ready_q, rf_ready_d;
  logic                      write_dropped_q, write_dropped_d;

  logic [RAM_DATA_WIDTH-1:0] mem [NUM_REGS];

  logic                      mem_we;
  logic [REG_ADDR_WIDTH-1:0] mem_waddr;
  logic [RAM_DATA_WIDTH-1:0] mem_wdata;

  // The register-0 test, the bypass and the gating by the ready flag are shared by both read ports.
  function automatic logic [RAM_DATA_WIDTH-1:0] read_port(
    input logic                      ready,
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic                      wr_en,
    input logic [REG_ADDR_WIDTH-1:0] wr_addr,
    input logic [RAM_DATA_WIDTH-1:0] wr_data,
    input logic [RAM_DATA_WIDTH-1:0] stored
  );
    logic [RAM_DATA_WIDTH-1:0] result;
    result = '0;
    if (ready && (addr != '0)) begin
      if (wr_en && (wr_addr == addr)) begin
        result = wr_data;
      end else begin
        result = stored;
      end
    end
    return result;
  endfunction

  always_comb begin
    state_d         = state_q;
    init_cnt_d      = init_cnt_q;
    rf_ready_d      = rf_ready_q;
    write_dropped_d = 1'b0;
    case (state_q)
      CLEAR: begin
        init_cnt_d      = init_cnt_q + REG_ADDR_WIDTH'(1);
        write_dropped_d = bus.reg_write;
        if (init_cnt_q == LAST_IDX) begin
          state_d    = READY;
          rf_ready_d = 1'b1;
        end
      end
      READY: begin
        rf_ready_d = 1'b1;
      end
      default: begin
        state_d    = CLEAR;
        init_cnt_d = '0;
        rf_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= CLEAR;
      init_cnt_q      <= '0;
      rf_ready_q      <= 1'b0;
      write_dropped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      rf_ready_q      <= rf_ready_d;
      write_dropped_q <= write_dropped_d;
    end
  end

  // The sweep owns the array write port until READY; after that only non-zero write-back targets update the array.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.write_reg;
    mem_wdata = bus.write_data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt_q;
      mem_wdata = '0;
    end else if (bus.reg_write && (bus.write_reg != '0)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.read_data1 = read_port(rf_ready_q, bus.read_reg1, bus.reg_write, bus.write_reg,
                                    bus.write_data, mem[bus.read_reg1]);
  assign bus.read_data2 = read_port(rf_ready_q, bus.read_reg2, bus.reg_write, bus.write_reg,
                                    bus.write_data, mem[bus.read_reg2]);
  assign bus.rf_ready      = rf_ready_q;
  assign bus.write_dropped = write_dropped_q;

endmodule

// File: tb/tb_ceyloniac_register_file.sv
// Self-checking bench for ceyloniac_register_file: directed scenarios plus random READY traffic
// checked against a reference array.
module tb_ceyloniac_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  logic [DW-1:0] ref_mem [NR];

  ceyloniac_register_file_if #(.RAM_DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) rf_if ();

  ceyloniac_register_file #(.RAM_DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value from the reference array, applying the read rules for register 0 and the write-first bypass.
  function automatic logic [DW-1:0] model_read(input logic ready, input logic [AW-1:0] addr,
                                               input logic we, input logic [AW-1:0] waddr,
                                               input logic [DW-1:0] wdata);
    if (!ready || addr == 0) return '0;
    if (we && waddr == addr) return wdata;
    return ref_mem[addr];
  endfunction

  task automatic drive_idle();
    rf_if.reg_write  = 1'b0;
    rf_if.write_reg  = '0;
    rf_if.write_data = '0;
    rf_if.read_reg1  = '0;
    rf_if.read_reg2  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs the 32-edge clear sweep from just before edge 1; drop_edge > 0 requests a write to r3 on that edge.
  task automatic run_sweep(input int drop_edge);
    for (int k = 1; k <= NR; k++) begin
      rf_if.reg_write  = (k == drop_edge);
      rf_if.write_reg  = 5'd3;
      rf_if.write_data = $urandom;
      rf_if.read_reg1  = (k == drop_edge) ? 5'd3 : AW'($urandom_range(0, NR - 1));
      rf_if.read_reg2  = AW'($urandom_range(0, NR - 1));
      #1;
      n_checks++;
      if (rf_if.read_data1 !== '0 || rf_if.read_data2 !== '0) begin
        n_fail++;
        $display("FAIL sweep_read edge %0d: got %h/%h required 0/0", k, rf_if.read_data1, rf_if.read_data2);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (rf_if.rf_ready !== (k == NR)) begin
        n_fail++;
        $display("FAIL sweep_ready edge %0d: got %b required %b", k, rf_if.rf_ready, (k == NR));
      end
      n_checks++;
      if (rf_if.write_dropped !== (k == drop_edge)) begin
        n_fail++;
        $display("FAIL sweep_dropped edge %0d: got %b required %b", k, rf_if.write_dropped, (k == drop_edge));
      end
    end
    rf_if.reg_write = 1'b0;
    for (int i = 0; i < NR; i++) ref_mem[i] = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    rf_if.read_reg1 = 5'd7;
    rf_if.read_reg2 = 5'd31;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (rf_if.rf_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 0", rf_if.rf_ready);
    end
    n_checks++;
    if (rf_if.write_dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dropped: got %b required 0", rf_if.write_dropped);
    end
    n_checks++;
    if (rf_if.read_data1 !== '0 || rf_if.read_data2 !== '0) begin
      n_fail++;
      $display("FAIL reset_read: got %h/%h required 0/0", rf_if.read_data1, rf_if.read_data2);
    end
  endtask

  task automatic test_sweep();
    do_reset();
    run_sweep(0);
  endtask

  task automatic test_write_read_bypass();
    rf_if.reg_write  = 1'b1;
    rf_if.write_reg  = 5'd5;
    rf_if.write_data = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    ref_mem[5] = 32'hDEADBEEF;
    rf_if.reg_write = 1'b0;
    rf_if.read_reg1 = 5'd5;
    rf_if.read_reg2 = 5'd6;
    #1;
    n_checks++;
    if (rf_if.read_data1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_read r5: got %h required deadbeef", rf_if.read_data1);
    end
    rf_if.reg_write  = 1'b1;
    rf_if.write_data = 32'h12345678;
    rf_if.read_reg2  = 5'd5;
    #1;
    n_checks++;
    if (rf_if.read_data2 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL bypass port2: got %h required 12345678", rf_if.read_data2);
    end
    n_checks++;
    if (rf_if.read_data1 !== rf_if.read_data2 || rf_if.read_data1 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL bypass same_addr: got %h/%h required 12345678 on both", rf_if.read_data1, rf_if.read_data2);
    end
    @(posedge clk);
    #1;
    ref_mem[5] = 32'h12345678;
    rf_if.reg_write = 1'b0;
    #1;
    n_checks++;
    if (rf_if.read_data1 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL write_read r5_second: got %h required 12345678", rf_if.read_data1);
    end
  endtask

  task automatic test_reg0();
    rf_if.reg_write  = 1'b1;
    rf_if.write_reg  = 5'd0;
    rf_if.write_data = 32'hFFFFFFFF;
    rf_if.read_reg1  = 5'd0;
    rf_if.read_reg2  = 5'd0;
    #1;
    n_checks++;
    if (rf_if.read_data1 !== '0 || rf_if.read_data2 !== '0) begin
      n_fail++;
      $display("FAIL reg0_before: got %h/%h required 0/0", rf_if.read_data1, rf_if.read_data2);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rf_if.write_dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL reg0_dropped: got %b required 0", rf_if.write_dropped);
    end
    rf_if.reg_write = 1'b0;
    #1;
    n_checks++;
    if (rf_if.read_data1 !== '0 || rf_if.read_data2 !== '0) begin
      n_fail++;
      $display("FAIL reg0_after: got %h/%h required 0/0", rf_if.read_data1, rf_if.read_data2);
    end
  endtask

  task automatic test_dropped_write();
    do_reset();
    run_sweep(10);
    rf_if.read_reg1 = 5'd3;
    rf_if.read_reg2 = 5'd3;
    #1;
    n_checks++;
    if (rf_if.read_data1 !== '0 || rf_if.read_data2 !== '0) begin
      n_fail++;
      $display("FAIL dropped_r3: got %h/%h required 0/0", rf_if.read_data1, rf_if.read_data2);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i < NR; i++) begin
      rf_if.reg_write  = 1'b1;
      rf_if.write_reg  = AW'(i);
      rf_if.write_data = DW'(i);
      @(posedge clk);
      #1;
      ref_mem[i] = DW'(i);
    end
    rf_if.reg_write = 1'b0;
    for (int i = 1; i < NR; i++) begin
      rf_if.read_reg1 = AW'(i);
      rf_if.read_reg2 = AW'(NR - i);
      #1;
      n_checks++;
      if (rf_if.read_data1 !== ref_mem[i] || rf_if.read_data2 !== ref_mem[NR - i]) begin
        n_fail++;
        $display("FAIL fill r%0d/r%0d: got %h/%h required %h/%h", i, NR - i,
                 rf_if.read_data1, rf_if.read_data2, ref_mem[i], ref_mem[NR - i]);
      end
    end
    rf_if.read_reg1 = 5'd7;
    rf_if.read_reg2 = 5'd31;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (rf_if.rf_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ready: got %b required 0", rf_if.rf_ready);
    end
    n_checks++;
    if (rf_if.read_data1 !== '0 || rf_if.read_data2 !== '0) begin
      n_fail++;
      $display("FAIL midreset_read: got %h/%h required 0/0", rf_if.read_data1, rf_if.read_data2);
    end
    #2;
    reset = 1'b1;
    run_sweep(0);
    for (int i = 0; i < NR; i++) begin
      rf_if.read_reg1 = AW'(i);
      rf_if.read_reg2 = AW'(NR - 1 - i);
      #1;
      n_checks++;
      if (rf_if.read_data1 !== '0 || rf_if.read_data2 !== '0) begin
        n_fail++;
        $display("FAIL resweep_clear r%0d/r%0d: got %h/%h required 0/0", i, NR - 1 - i,
                 rf_if.read_data1, rf_if.read_data2);
      end
    end
  endtask

  task automatic test_random_traffic();
    logic [DW-1:0] exp1, exp2;
    for (int c = 0; c < 2000; c++) begin
      rf_if.read_reg1  = AW'($urandom_range(0, NR - 1));
      rf_if.read_reg2  = ($urandom_range(0, 3) == 0) ? rf_if.read_reg1 : AW'($urandom_range(0, NR - 1));
      rf_if.reg_write  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       rf_if.write_reg = rf_if.read_reg1;
        1:       rf_if.write_reg = rf_if.read_reg2;
        default: rf_if.write_reg = AW'($urandom_range(0, NR - 1));
      endcase
      rf_if.write_data = $urandom;
      #1;
      exp1 = model_read(1'b1, rf_if.read_reg1, rf_if.reg_write, rf_if.write_reg, rf_if.write_data);
      exp2 = model_read(1'b1, rf_if.read_reg2, rf_if.reg_write, rf_if.write_reg, rf_if.write_data);
      n_checks++;
      if (rf_if.read_data1 !== exp1 || rf_if.read_data2 !== exp2) begin
        n_fail++;
        $display("FAIL random cycle %0d ra=%0d rb=%0d: got %h/%h required %h/%h", c,
                 rf_if.read_reg1, rf_if.read_reg2, rf_if.read_data1, rf_if.read_data2, exp1, exp2);
      end
      @(posedge clk);
      if (rf_if.reg_write && rf_if.write_reg != 0) ref_mem[rf_if.write_reg] = rf_if.write_data;
      #1;
      n_checks++;
      if (rf_if.write_dropped !== 1'b0 || rf_if.rf_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL random_status cycle %0d: got dropped=%b ready=%b required 0/1", c,
                 rf_if.write_dropped, rf_if.rf_ready);
      end
    end
    rf_if.reg_write = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < NR; i++) ref_mem[i] = '0;
    test_reset();
    test_sweep();
    test_write_read_bypass();
    test_reg0();
    test_dropped_write();
    test_reset_mid();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ceyloniac_register_file.md
Name: ceyloniac_register_file

Overview:
- General-purpose register file for the ceyloniac multicycle core.
- It is the source end of the operand path: its two combinational read ports drive read_data1/read_data2 into the A/B operand latch stage. Its single write port accepts write-back results.
- After reset, a sweep state machine clears every entry one per cycle, so the array can map to distributed RAM with no per-entry reset. rf_ready tells the control unit when the file is usable.

Parameters:
- RAM_DATA_WIDTH, 32, width of each register and of all data ports.
- REG_ADDR_WIDTH, 5, register address width. NUM_REGS = 2**REG_ADDR_WIDTH (local, derived).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- read_reg1  input  REG_ADDR_WIDTH  read port 1 address
- read_reg2  input  REG_ADDR_WIDTH  read port 2 address
- read_data1  output  RAM_DATA_WIDTH  read port 1 data (combinational)
- read_data2  output  RAM_DATA_WIDTH  read port 2 data (combinational)
- reg_write  input  1  write enable, sampled on rising clk
- write_reg  input  REG_ADDR_WIDTH  write address
- write_data  input  RAM_DATA_WIDTH  write data
- rf_ready  output  1  1 = sweep complete, reads/writes valid
- write_dropped  output  1  one-cycle pulse: a write was rejected during the sweep

Behaviour:
- States: CLEAR, READY. State register, init_cnt, rf_ready and write_dropped reset asynchronously.
- reset=0: state=CLEAR, init_cnt=0, rf_ready=0, write_dropped=0. read_data1/2 forced to 0. The array holds its contents but they are treated as invalid.
- CLEAR: each rising edge writes mem[init_cnt]=0 and increments init_cnt.
  - When init_cnt==NUM_REGS-1 on a rising edge, that entry is cleared, state goes to READY and rf_ready goes to 1.
  - rf_ready therefore rises on the NUM_REGS-th rising edge after reset release (32 by default).
- In CLEAR:
  - read_data1/2 = 0.
  - reg_write=1 is ignored (no array update). write_dropped=1 for the following cycle (registered pulse), else 0.
- READY, write:
  - On a rising edge with reg_write=1 and write_reg!=0, mem[write_reg] <= write_data.
  - write_reg==0 is silently ignored. write_dropped stays 0.
- READY, read:
  - read_dataN = 0 if read_regN==0.
  - Otherwise, if reg_write=1 and write_reg==read_regN, read_dataN = write_data (write-first bypass, same cycle).
  - Otherwise read_dataN = mem[read_regN].
- Both read ports are independent. Equal addresses on both ports return identical data, including under bypass.
- Register 0 always reads 0 in every state and is never written with non-zero data.
- Reset asserted mid-sweep or in READY: immediate return to CLEAR with outputs as for reset. A full sweep restarts on release.
- No state other than these exists. READY is held until reset.

Test Plan:
- Release reset, count edges -> rf_ready=0 for edges 1..31, rf_ready=1 after edge 32; read_data1/2=0 throughout the sweep.
- Sweep, then write 0xDEADBEEF to r5, then read_reg1=5 next cycle -> read_data1=0xDEADBEEF. Write r5 again with 0x12345678 while read_reg2=5 in the same cycle -> read_data2=0x12345678 combinationally (bypass).
- After sweep, reg_write=1, write_reg=0, write_data=0xFFFFFFFF; read_reg1=read_reg2=0 -> both read 0 before and after the edge; write_dropped=0.
- reg_write=1 to r3 at sweep cycle 10 -> write_dropped=1 for exactly one cycle; after rf_ready, read r3 -> 0.
- Fill r1..r31 with value = index, assert reset for 3 ns mid-cycle -> rf_ready=0 and read_data=0 immediately. After release and a new 32-cycle sweep, all registers read 0.
- Random READY traffic against a reference-array model for 2000 cycles, both ports hitting write_reg often -> zero mismatches.
